// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_pkg
//  Description : Shared constants for the bit-serial subtractor: FSM state
//                encodings and the default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

  // Default operand / result width
  localparam int DEFAULT_WIDTH = 4;

  // FSM state encodings
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage : serial_subtractor_pkg
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor
//  Description : Combinational one-bit full-subtractor cell, x - y - b_in.
//  Ports       : x_in       - minuend bit
//                y_in       - subtrahend bit
//                b_in       - incoming borrow
//                diff_out   - difference bit
//                borrow_out - outgoing borrow
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  logic x_in,
  input  logic y_in,
  input  logic b_in,
  output logic diff_out,
  output logic borrow_out
);

  assign diff_out   = x_in ^ y_in ^ b_in;
  // Borrow when y exceeds x, or when x == y and a borrow is already pending
  assign borrow_out = (~x_in & y_in) | (~(x_in ^ y_in) & b_in);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial multi-cycle subtractor. Computes
//                diff = a - b - borrow_in (mod 2^WIDTH) over WIDTH cycles,
//                LSB first, reusing one full-subtractor cell.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                start      - request, sampled in IDLE only
//                a, b       - minuend / subtrahend, captured on start
//                borrow_in  - initial borrow, captured on start
//                busy       - high while shifting
//                done       - one-cycle completion pulse
//                diff       - result, held until next completion
//                borrow_out - final borrow (a < b + borrow_in)
//                zero       - diff == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic             r_zero;

  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Single reused cell operating on the current LSBs
  full_subtractor u_cell (
    .x_in       (r_a_sh[0]),
    .y_in       (r_b_sh[0]),
    .b_in       (r_brw),
    .diff_out   (w_d),
    .borrow_out (w_bout)
  );

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 is the LSB
  assign w_res_next = {w_d, r_res_sh[WIDTH-1:1]};
  assign w_last     = (r_cnt == C_LAST_CNT);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_res_sh     <= '0;
      r_brw        <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_brw    <= borrow_in;
            r_cnt    <= '0;
            r_res_sh <= '0;
          end
        end
        ST_SHIFT: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_brw    <= w_bout;
          r_res_sh <= w_res_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          // Published results change only here, so they hold across new starts
          if (w_last) begin
            r_diff       <= w_res_next;
            r_borrow_out <= w_bout;
            r_zero       <= (w_res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;
  assign zero       = r_zero;

endmodule : serial_subtractor
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor: computes diff = a - b - borrow_in over WIDTH clock cycles, LSB first, one full-subtractor cell reused every cycle.
- Inverse-operation companion to the team's combinational ripple adder datapath.
- Uses a start/busy/done handshake so that a controller can drive it. Trades area for latency in narrow control paths.

Parameters:
- WIDTH, 4, operand and result width in bits (legal: 2..32).
- CNT_W, $clog2(WIDTH), width of the internal bit counter (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- borrow_in  input  1  initial borrow; captured on accepted start.
- busy  output  1  high while the operation is in progress (SHIFT state).
- done  output  1  one-cycle completion pulse.
- diff  output  WIDTH  result, held stable until the next completion.
- borrow_out  output  1  final borrow (1 = a < b + borrow_in, unsigned).
- zero  output  1  diff == 0, updated together with diff.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, zero=0, counter=0, internal shift registers=0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 at an edge loads a_sh<=a, b_sh<=b, brw<=borrow_in, cnt<=0, res_sh<=0, then goes to SHIFT. Otherwise stays in IDLE.
  - SHIFT: each edge applies the full-subtractor to a_sh[0], b_sh[0] and brw:
    - d bit shifts into res_sh MSB (right shift).
    - a_sh and b_sh shift right; brw <= bout; cnt++.
    - When cnt == WIDTH-1 at the edge: diff <= final res_sh, borrow_out <= final bout, zero <= (final result == 0), and the FSM goes to DONE.
  - DONE: done=1 for exactly one cycle, then unconditional transition to IDLE.
- Cell equations: d = x ^ y ^ bin; bout = (~x & y) | (~(x ^ y) & bin).
- Latency: start high in cycle 0 gives busy high in cycles 1..WIDTH and done high in cycle WIDTH+1. diff, borrow_out and zero are valid from cycle WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. start is accepted only in IDLE and ignored in SHIFT and DONE (no queuing).
- Operand stability: a, b and borrow_in may change freely after the start edge.
- Arithmetic: modulo 2^WIDTH. diff = (a - b - borrow_in) mod 2^WIDTH. borrow_out = 1 exactly when a < b + borrow_in as unbounded unsigned.
- Output hold: diff, borrow_out and zero are not cleared on a new start; they change only at the final SHIFT edge or on reset.
- Reset mid-operation: rst at any edge overrides all other activity. The FSM returns to IDLE, outputs go to their reset values, and no done pulse is produced for the aborted operation.
- Simultaneous rst and start: reset wins and start is dropped.
- done and busy are never high in the same cycle.

Decomposition:
- Shared package/include:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - default WIDTH constant.
- Sub-module: full_subtractor, a combinational one-bit cell.
  - Ports: x_in, y_in, b_in, diff_out, borrow_out.
  - Instantiated once; reusable elsewhere as the subtract counterpart of the full-adder cell.

Test Plan:
- Reset: hold rst for 2 cycles, then release -> busy=0, done=0, diff=0, borrow_out=0, zero=0; no activity without start.
- Basic subtract: a=9, b=5, borrow_in=0, start pulse in cycle 0 -> busy in cycles 1-4, done in cycle 5, diff=4, borrow_out=0, zero=0.
- Underflow with borrow_in:
  - a=5, b=9, borrow_in=0 -> diff=4'hC, borrow_out=1.
  - a=0, b=0, borrow_in=1 -> diff=4'hF, borrow_out=1, zero=0.
- Zero flag: a=7, b=7, borrow_in=0 -> diff=0, zero=1, borrow_out=0. Results then held unchanged across 10 idle cycles.
- Start while busy or done:
  - Start a=3, b=1. Pulse start with a=15, b=0 in cycles 2 and 5 -> only one done, in cycle 5, with diff=2.
  - A fresh start in cycle 6 -> accepted, done in cycle 11.
- Reset mid-operation: start a=12, b=4, assert rst in cycle 2 -> no done pulse ever; outputs are 0 from cycle 3. A following start a=12, b=4 -> diff=8 after the normal latency.
- Parameter sweep (WIDTH=8): 1000 random a, b, borrow_in vs a reference model -> diff, borrow_out and zero all match, and done always occurs at cycle 9.
